// File: rtl/console_tx.sv
// console_tx: FIFO-buffered framed character transmitter (start=0, stop=all ones).
// Optional simulation echo of transmitted text: define CONSOLE_TX_SIM_ECHO_EN.
module console_tx #(
  parameter int CHAR_WIDTH   = 7,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_SYM = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [CHAR_WIDTH-1:0]        wr_char,
  input  logic                         wr_eom,
  input  logic                         ovf_clr,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         overflow,
  output logic [CHAR_WIDTH-1:0]        tx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(CLKS_PER_SYM - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state, state_next;

  logic [CHAR_WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [SW-1:0]         sym_cnt;
  logic                  eom_q, eom_next;
  logic [CHAR_WIDTH-1:0] tx_next;
  logic [CHAR_WIDTH-1:0] head_char;
  logic                  head_eom;
  logic [CW-1:0]         count_next;
  logic                  push, pop;
  logic                  sym_done, empty;

  assign {head_eom, head_char} = mem[rd_ptr];
  assign push     = wr_en && !full;
  assign empty    = (count == '0);
  assign sym_done = (sym_cnt == SYM_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pops happen only on DATA entry; count is known non-zero there.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    eom_next   = eom_q;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        tx_next = '1;
        if (!empty) begin
          state_next = START;
          tx_next    = '0;
        end
      end
      START: begin
        if (sym_done) begin
          state_next = DATA;
          pop        = 1'b1;
          tx_next    = head_char;
          eom_next   = head_eom;
        end
      end
      DATA: begin
        if (sym_done) begin
          if (eom_q || empty) begin
            state_next = STOP;
            tx_next    = '1;
          end else begin
            state_next = DATA;
            pop        = 1'b1;
            tx_next    = head_char;
            eom_next   = head_eom;
          end
        end
      end
      STOP: begin
        if (sym_done) begin
          if (!empty) begin
            state_next = START;
            tx_next    = '0;
          end else begin
            state_next = IDLE;
            tx_next    = '1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {wr_eom, wr_char};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= '1;
      eom_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      sym_cnt  <= '0;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      eom_q <= eom_next;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      if (ovf_clr)
        overflow <= 1'b0;
      else if (wr_en && full)
        overflow <= 1'b1;
      // Every non-idle transition lands on sym_done, so this restarts per entry.
      if (state == IDLE || sym_done)
        sym_cnt <= '0;
      else
        sym_cnt <= sym_cnt + SW'(1);
    end
  end

`ifdef CONSOLE_TX_SIM_ECHO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (pop)
        $write("%c", 8'(head_char));
      if (state == DATA && state_next == STOP && eom_q)
        $write("\n");
    end
  end
`else
  // no simulator output in this build
`endif

endmodule

// File: tb/tb_console_tx.sv
// tb_console_tx: randomized frame checks of console_tx against a frame-list model.
// Three instances cover default, slow-symbol and small-FIFO configurations.
module tb_console_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic       d_wr_en, d_wr_eom, d_ovf_clr, d_full, d_busy, d_ovf;
  logic [6:0] d_wr_char, d_tx;
  logic [4:0] d_count;

  logic       s_wr_en, s_wr_eom, s_ovf_clr, s_full, s_busy, s_ovf;
  logic [6:0] s_wr_char, s_tx;
  logic [4:0] s_count;

  logic       m_wr_en, m_wr_eom, m_ovf_clr, m_full, m_busy, m_ovf;
  logic [6:0] m_wr_char, m_tx;
  logic [2:0] m_count;

  console_tx u_dflt (
    .clk(clk), .reset(rst_n),
    .wr_en(d_wr_en), .wr_char(d_wr_char), .wr_eom(d_wr_eom),
    .ovf_clr(d_ovf_clr), .full(d_full), .count(d_count),
    .busy(d_busy), .overflow(d_ovf), .tx(d_tx)
  );

  console_tx #(.CLKS_PER_SYM(3)) u_slow (
    .clk(clk), .reset(rst_n),
    .wr_en(s_wr_en), .wr_char(s_wr_char), .wr_eom(s_wr_eom),
    .ovf_clr(s_ovf_clr), .full(s_full), .count(s_count),
    .busy(s_busy), .overflow(s_ovf), .tx(s_tx)
  );

  console_tx #(.DEPTH(4), .CLKS_PER_SYM(8)) u_small (
    .clk(clk), .reset(rst_n),
    .wr_en(m_wr_en), .wr_char(m_wr_char), .wr_eom(m_wr_eom),
    .ovf_clr(m_ovf_clr), .full(m_full), .count(m_count),
    .busy(m_busy), .overflow(m_ovf), .tx(m_tx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A burst that never lets the FIFO run dry splits only on eom or at its end.
  function automatic void build_frames(
    input  logic [6:0] ch[$],
    input  logic       eo[$],
    output logic [6:0] sym[$]
  );
    bit open;
    open = 1'b0;
    sym  = {};
    foreach (ch[i]) begin
      if (!open) begin
        sym.push_back(7'h00);
        open = 1'b1;
      end
      sym.push_back(ch[i]);
      if (eo[i] || i == ch.size() - 1) begin
        sym.push_back(7'h7F);
        open = 1'b0;
      end
    end
  endfunction

  task automatic test_reset();
    total++;
    if (d_tx !== 7'h7F) begin
      bad++; $display("FAIL reset_tx got=%h want=7f", d_tx);
    end
    total++;
    if (d_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", d_busy);
    end
    total++;
    if (d_full !== 1'b0) begin
      bad++; $display("FAIL reset_full got=%b want=0", d_full);
    end
    total++;
    if (d_count !== 5'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", d_count);
    end
    total++;
    if (d_ovf !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%b want=0", d_ovf);
    end
    total++;
    if (s_tx !== 7'h7F || m_tx !== 7'h7F) begin
      bad++; $display("FAIL reset_tx_cfg got=%h/%h want=7f", s_tx, m_tx);
    end
  endtask

  task automatic test_frames_default();
    logic [6:0] ch[$];
    logic       eo[$];
    logic [6:0] sym[$];
    logic [6:0] exp_tx;
    logic       exp_busy;
    int         n, busy_n;
    for (int sc = 0; sc < 6; sc++) begin
      ch = {}; eo = {};
      if (sc == 0) begin
        ch = {7'h48, 7'h69}; eo = {1'b0, 1'b1};
      end else if (sc == 1) begin
        ch = {7'h61, 7'h62}; eo = {1'b1, 1'b1};
      end else begin
        n = $urandom_range(1, 16);
        for (int i = 0; i < n; i++) begin
          ch.push_back(7'($urandom));
          eo.push_back($urandom_range(0, 3) == 0);
        end
      end
      build_frames(ch, eo, sym);
      busy_n = 0;
      d_wr_en = 1'b1; d_wr_char = ch[0]; d_wr_eom = eo[0];
      for (int k = 0; k < sym.size() + 2; k++) begin
        tick();
        if (k + 1 < ch.size()) begin
          d_wr_char = ch[k+1]; d_wr_eom = eo[k+1];
        end else begin
          d_wr_en = 1'b0;
        end
        exp_tx = 7'h7F; exp_busy = 1'b0;
        if (k >= 1 && k - 1 < sym.size()) begin
          exp_tx = sym[k-1]; exp_busy = 1'b1;
        end
        total++;
        if (d_tx !== exp_tx) begin
          bad++;
          $display("FAIL dflt_tx sc=%0d cyc=%0d got=%h want=%h", sc, k, d_tx, exp_tx);
        end
        total++;
        if (d_busy !== exp_busy) begin
          bad++;
          $display("FAIL dflt_busy sc=%0d cyc=%0d got=%b want=%b", sc, k, d_busy, exp_busy);
        end
        if (d_busy === 1'b1) busy_n++;
        if (k == 0) begin
          total++;
          if (d_count !== 5'd1) begin
            bad++; $display("FAIL dflt_count_e0 sc=%0d got=%0d want=1", sc, d_count);
          end
        end
      end
      total++;
      if (busy_n != sym.size()) begin
        bad++; $display("FAIL dflt_busy_len sc=%0d got=%0d want=%0d", sc, busy_n, sym.size());
      end
      total++;
      if (d_count !== 5'd0) begin
        bad++; $display("FAIL dflt_count_end sc=%0d got=%0d want=0", sc, d_count);
      end
    end
  endtask

  task automatic test_rate_slow();
    logic [6:0] ch[$];
    logic       eo[$];
    logic [6:0] sym[$];
    logic [6:0] exp_tx;
    logic       exp_busy;
    int         n, len;
    for (int sc = 0; sc < 4; sc++) begin
      ch = {}; eo = {};
      if (sc == 0) begin
        ch = {7'h41}; eo = {1'b1};
      end else begin
        n = $urandom_range(2, 16);
        for (int i = 0; i < n; i++) begin
          ch.push_back(7'($urandom));
          eo.push_back($urandom_range(0, 2) == 0);
        end
      end
      build_frames(ch, eo, sym);
      len = sym.size() * 3;
      s_wr_en = 1'b1; s_wr_char = ch[0]; s_wr_eom = eo[0];
      for (int k = 0; k < len + 2; k++) begin
        tick();
        if (k + 1 < ch.size()) begin
          s_wr_char = ch[k+1]; s_wr_eom = eo[k+1];
        end else begin
          s_wr_en = 1'b0;
        end
        exp_tx = 7'h7F; exp_busy = 1'b0;
        if (k >= 1 && k - 1 < len) begin
          exp_tx = sym[(k-1)/3]; exp_busy = 1'b1;
        end
        total++;
        if (s_tx !== exp_tx || s_busy !== exp_busy) begin
          bad++;
          $display("FAIL slow_sym sc=%0d cyc=%0d got=%h/%b want=%h/%b",
                   sc, k, s_tx, s_busy, exp_tx, exp_busy);
        end
      end
      total++;
      if (s_count !== 5'd0 || s_full !== 1'b0) begin
        bad++; $display("FAIL slow_end sc=%0d got=%0d/%b want=0/0", sc, s_count, s_full);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] ch[$];
    ch = {7'h78, 7'h79, 7'h7A};
    d_wr_en = 1'b1; d_wr_char = ch[0]; d_wr_eom = 1'b0;
    tick();
    d_wr_char = ch[1];
    tick();
    d_wr_char = ch[2]; d_wr_eom = 1'b1;
    tick();
    d_wr_en = 1'b0; d_wr_eom = 1'b0;
    total++;
    if (d_tx !== ch[0]) begin
      bad++; $display("FAIL mid_data got=%h want=%h", d_tx, ch[0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (d_tx !== 7'h7F || d_count !== 5'd0 || d_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%0d/%b want=7f/0/0", d_tx, d_count, d_busy);
    end
    d_wr_en = 1'b1; d_wr_char = 7'h51; d_wr_eom = 1'b1;
    tick();
    d_wr_en = 1'b0;
    total++;
    if (d_count !== 5'd1 || d_tx !== 7'h7F) begin
      bad++; $display("FAIL mid_after_wr got=%0d/%h want=1/7f", d_count, d_tx);
    end
    tick();
    total++;
    if (d_tx !== 7'h00 || d_busy !== 1'b1) begin
      bad++; $display("FAIL mid_start got=%h/%b want=00/1", d_tx, d_busy);
    end
    tick();
    total++;
    if (d_tx !== 7'h51) begin
      bad++; $display("FAIL mid_char got=%h want=51", d_tx);
    end
    tick();
    total++;
    if (d_tx !== 7'h7F || d_busy !== 1'b1) begin
      bad++; $display("FAIL mid_stop got=%h/%b want=7f/1", d_tx, d_busy);
    end
    tick();
    total++;
    if (d_busy !== 1'b0 || d_count !== 5'd0) begin
      bad++; $display("FAIL mid_idle got=%b/%0d want=0/0", d_busy, d_count);
    end
  endtask

  task automatic test_overflow();
    logic [6:0] ch[$];
    logic       eo[$];
    logic [6:0] kept[$];
    logic       keo[$];
    logic [6:0] sym[$];
    logic [6:0] exp_tx;
    int         len;
    for (int i = 0; i < 6; i++) begin
      ch.push_back(7'($urandom));
      eo.push_back(1'b0);
      if (i < 4) begin
        kept.push_back(ch[i]); keo.push_back(1'b0);
      end
    end
    build_frames(kept, keo, sym);
    len = sym.size() * 8;
    m_wr_en = 1'b1; m_wr_char = ch[0]; m_wr_eom = eo[0];
    for (int k = 0; k < len + 2; k++) begin
      tick();
      if (k + 1 < ch.size()) begin
        m_wr_char = ch[k+1]; m_wr_eom = eo[k+1];
      end else begin
        m_wr_en = 1'b0;
      end
      exp_tx = 7'h7F;
      if (k >= 1 && k - 1 < len) exp_tx = sym[(k-1)/8];
      total++;
      if (m_tx !== exp_tx) begin
        bad++; $display("FAIL ovf_tx cyc=%0d got=%h want=%h", k, m_tx, exp_tx);
      end
      if (k == 2 || k == 3) begin
        total++;
        if (m_full !== (k == 3)) begin
          bad++; $display("FAIL ovf_full cyc=%0d got=%b want=%b", k, m_full, k == 3);
        end
      end
      if (k == 3 || k == 4) begin
        total++;
        if (m_ovf !== (k == 4)) begin
          bad++; $display("FAIL ovf_flag cyc=%0d got=%b want=%b", k, m_ovf, k == 4);
        end
      end
      if (k == 5) begin
        total++;
        if (m_count !== 3'd4) begin
          bad++; $display("FAIL ovf_count got=%0d want=4", m_count);
        end
      end
    end
    total++;
    if (m_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%b want=1", m_ovf);
    end
    m_ovf_clr = 1'b1;
    tick();
    m_ovf_clr = 1'b0;
    total++;
    if (m_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clr got=%b want=0", m_ovf);
    end
  endtask

  task automatic test_full_pop();
    logic [6:0] ch[$];
    int         waited;
    for (int i = 0; i < 4; i++) ch.push_back(7'($urandom));
    m_wr_en = 1'b1; m_wr_char = ch[0]; m_wr_eom = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      m_ovf_clr = 1'b0;
      if (k + 1 < 4) begin
        m_wr_en = 1'b1; m_wr_char = ch[k+1];
      end else if (k + 1 == 4) begin
        m_wr_en = 1'b1; m_ovf_clr = 1'b1; m_wr_char = 7'($urandom);
      end else if (k + 1 == 9) begin
        m_wr_en = 1'b1; m_wr_char = 7'($urandom);
      end else begin
        m_wr_en = 1'b0;
      end
      if (k == 4) begin
        total++;
        if (m_ovf !== 1'b0 || m_count !== 3'd4) begin
          bad++; $display("FAIL fp_clr_prio got=%b/%0d want=0/4", m_ovf, m_count);
        end
      end
      if (k == 8) begin
        total++;
        if (m_count !== 3'd4 || m_tx !== 7'h00 || m_full !== 1'b1) begin
          bad++; $display("FAIL fp_pre got=%0d/%h/%b want=4/00/1", m_count, m_tx, m_full);
        end
      end
      if (k == 9) begin
        total++;
        if (m_count !== 3'd3 || m_full !== 1'b0 || m_ovf !== 1'b1) begin
          bad++;
          $display("FAIL fp_pop got=%0d/%b/%b want=3/0/1", m_count, m_full, m_ovf);
        end
        total++;
        if (m_tx !== ch[0]) begin
          bad++; $display("FAIL fp_head got=%h want=%h", m_tx, ch[0]);
        end
      end
    end
    m_wr_en = 1'b0;
    waited = 0;
    while (m_busy === 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    total++;
    if (m_busy !== 1'b0 || m_count !== 3'd0) begin
      bad++; $display("FAIL fp_drain got=%b/%0d want=0/0 waited=%0d", m_busy, m_count, waited);
    end
    m_ovf_clr = 1'b1;
    tick();
    m_ovf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    d_wr_en = 1'b0; d_wr_char = '0; d_wr_eom = 1'b0; d_ovf_clr = 1'b0;
    s_wr_en = 1'b0; s_wr_char = '0; s_wr_eom = 1'b0; s_ovf_clr = 1'b0;
    m_wr_en = 1'b0; m_wr_char = '0; m_wr_eom = 1'b0; m_ovf_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_frames_default();
    test_rate_slow();
    test_reset_mid();
    test_overflow();
    test_full_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
